pipeline_stall_controller: RTL and testbench
============================================

# pipeline_stall_controller

Sequences the MIPS pipeline's advance, stall and halt behaviour around the hazard detection unit. It gates PC, IF/ID and ID/EX updates from the hazard unit's load/jump/halt flags and from debug-unit run/step commands. It generates the registered jump-stop feedback the hazard unit needs to release a branch stall after one cycle. It drains the pipeline after HALT and reports completion and the number of executed cycles.

## Interface
- DRAIN_CYCLES, 4, advance cycles from HALT acceptance until the pipeline is empty; must be ≥1.
- i_clk  in  1  pipeline clock; all state changes on its rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_enable  in  1  continuous-run enable from the debug unit.
- i_step_mode  in  1  1 = step mode (advance only on i_step); 0 = continuous mode.
- i_step  in  1  one-cycle step pulse; valid in step mode only.
- i_flush  in  1  synchronous restart to IDLE; highest priority after reset.
- i_hd_jmp_stop  in  1  hazard unit o_jmp_stop.
- i_hd_not_load  in  1  hazard unit o_not_load (load-use or jump stall).
- i_hd_halt  in  1  hazard unit o_halt.
- o_jump_stop  out  1  registered; drives the hazard unit i_jump_stop input.
- o_pipe_en  out  1  global stage enable for this cycle.
- o_pc_we  out  1  PC write enable.
- o_if_id_we  out  1  IF/ID latch write enable.
- o_id_ex_bubble  out  1  load a NOP into ID/EX instead of the decoded instruction.
- o_halted  out  1  pipeline drained after HALT.
- o_state  out  2  IDLE=0, RUN=1, DRAIN=2, HALTED=3.
- o_cycle_count  out  32  number of advance cycles since reset or flush.

## Operation
- advance = (o_state ∈ {RUN, DRAIN}) && (i_step_mode ? i_step : i_enable). It is combinational, and o_pipe_en = advance.

States and transitions:
- IDLE: all enables 0. Goes to RUN when start = (i_step_mode ? i_step : i_enable). The start cycle itself does not advance.
- RUN, advance with i_hd_not_load=1 (stall): o_pc_we=0, o_if_id_we=0, o_id_ex_bubble=1.
- RUN, advance with i_hd_not_load=0 and i_hd_halt=0: o_pc_we=1, o_if_id_we=1, o_id_ex_bubble=0.
- RUN, advance with i_hd_not_load=0 and i_hd_halt=1 (HALT accepted): o_pc_we=0, o_if_id_we=0, o_id_ex_bubble=0, so HALT moves into ID/EX. Load the drain counter with DRAIN_CYCLES and go to DRAIN.
- RUN with no advance: all enables 0; state holds.
- DRAIN: o_pc_we=0, o_if_id_we=0, o_id_ex_bubble=advance. Each advance decrements the counter. An advance while counter==1 goes to HALTED. Hazard inputs are ignored.
- HALTED: all enables 0, o_halted=1. Leaves only via i_flush or reset.

o_jump_stop:
- On an advance cycle in RUN it loads i_hd_jmp_stop; otherwise it holds.
- It is cleared on entering DRAIN.
- Result: a branch/JR/JALR in ID stalls exactly one advance cycle, then proceeds.

o_cycle_count:
- +1 on every advance cycle, including stall and drain cycles.
- Saturates at 0xFFFFFFFF.

i_flush:
- Next state is IDLE; o_jump_stop, the drain counter and o_cycle_count are cleared.
- During the flush cycle all enables are forced to 0 and o_pipe_en=0.

Other rules:
- Switching i_step_mode takes effect on the same cycle, with no state change.
- An i_step pulse while i_step_mode=0 is ignored.

## Timing
- Reset values: o_state=IDLE, o_jump_stop=0, o_halted=0, o_cycle_count=0, drain counter=0. Consequently o_pipe_en, o_pc_we, o_if_id_we and o_id_ex_bubble are all 0.
- Enables and bubble are combinational from state and inputs, with zero-cycle latency.
- o_jump_stop, o_state, o_halted and o_cycle_count update on the clock edge ending an advance (or transition) cycle.
- From HALT acceptance in cycle N, in continuous mode with i_enable held: DRAIN occupies cycles N+1 to N+DRAIN_CYCLES, and o_halted=1 from cycle N+DRAIN_CYCLES+1.
- Reset asserted at any time, including mid-DRAIN or mid-stall, returns all registers to reset values immediately, without waiting for a clock.
- Flush and advance in the same cycle: flush wins and no count increment occurs.

## Test plan
- Load-use: RUN, i_enable=1, i_hd_not_load=1 for one cycle → that cycle o_pc_we=0, o_if_id_we=0, o_id_ex_bubble=1, o_pipe_en=1. Next cycle with not_load=0 → o_pc_we=1. o_cycle_count increases by 2.
- Branch: i_hd_jmp_stop=1 and i_hd_not_load=1 on an advance cycle → o_jump_stop=1 the next cycle. With both inputs then 0 → o_jump_stop returns to 0 one cycle later.
- HALT drain, DRAIN_CYCLES=4: HALT accepted in cycle 10 → o_state=DRAIN in cycles 11–14 with o_id_ex_bubble=1, o_state=HALTED and o_halted=1 from cycle 15. o_cycle_count stops at accepted-cycle count+4.
- Step mode: i_step_mode=1, i_enable=1, three isolated i_step pulses from RUN → o_pipe_en high exactly 3 cycles and o_cycle_count=3. o_jump_stop holds its value between pulses.
- Flush from HALTED: i_flush=1 → o_state=IDLE, o_halted=0, o_cycle_count=0, o_jump_stop=0 on the next cycle. Then i_enable=1 → RUN after one cycle.
- Async reset: i_reset=0 mid-DRAIN (counter=2) between clock edges → o_state=IDLE and o_cycle_count=0 immediately. After release, no advance until a start condition.

Source files
------------

// File: rtl/pipeline_stall_controller.sv
// Pipeline stall controller: sequences advance/stall/halt of the MIPS pipeline
// from hazard-unit flags and debug-unit run/step commands, drains the pipeline
// after HALT and counts executed (advance) cycles.
module pipeline_stall_controller #(
  parameter int DRAIN_CYCLES = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_enable,
  input  logic        i_step_mode,
  input  logic        i_step,
  input  logic        i_flush,
  input  logic        i_hd_jmp_stop,
  input  logic        i_hd_not_load,
  input  logic        i_hd_halt,
  output logic        o_jump_stop,
  output logic        o_pipe_en,
  output logic        o_pc_we,
  output logic        o_if_id_we,
  output logic        o_id_ex_bubble,
  output logic        o_halted,
  output logic [1:0]  o_state,
  output logic [31:0] o_cycle_count
);

  localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] drain_cnt;
  logic             go;
  logic             advance;
  logic             halt_accept;
  logic             drain_done;

  // The debug unit's run request: a step pulse in step mode, else the enable level.
  assign go          = i_step_mode ? i_step : i_enable;
  // A flush forces a dead cycle, so it also suppresses the advance.
  assign advance     = ((state == RUN) || (state == DRAIN)) && go && !i_flush;
  assign halt_accept = (state == RUN) && advance && !i_hd_not_load && i_hd_halt;
  assign drain_done  = (state == DRAIN) && advance && (drain_cnt == CNT_W'(1));

  assign o_pipe_en = advance;
  assign o_state   = state;
  assign o_halted  = (state == HALTED);

  // State register with asynchronous reset.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; flush overrides every other transition.
  always_comb begin
    next_state = state;
    if (i_flush) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    if (go) next_state = RUN;
        RUN:     if (halt_accept) next_state = DRAIN;
        DRAIN:   if (drain_done) next_state = HALTED;
        HALTED:  next_state = HALTED;
        default: next_state = IDLE;
      endcase
    end
  end

  // Stage enables and ID/EX bubble for the current cycle.
  always_comb begin
    o_pc_we        = 1'b0;
    o_if_id_we     = 1'b0;
    o_id_ex_bubble = 1'b0;
    if (advance) begin
      if (state == RUN) begin
        if (i_hd_not_load) begin
          o_id_ex_bubble = 1'b1;
        end else if (!i_hd_halt) begin
          o_pc_we    = 1'b1;
          o_if_id_we = 1'b1;
        end
      end else begin
        o_id_ex_bubble = 1'b1;
      end
    end
  end

  // Drain countdown, loaded when HALT moves into ID/EX.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      drain_cnt <= '0;
    end else if (i_flush) begin
      drain_cnt <= '0;
    end else if (halt_accept) begin
      drain_cnt <= CNT_W'(DRAIN_CYCLES);
    end else if ((state == DRAIN) && advance) begin
      drain_cnt <= drain_cnt - CNT_W'(1);
    end
  end

  // Jump-stop feedback lets the hazard unit release a branch stall after one advance.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_jump_stop <= 1'b0;
    end else if (i_flush || halt_accept) begin
      o_jump_stop <= 1'b0;
    end else if ((state == RUN) && advance) begin
      o_jump_stop <= i_hd_jmp_stop;
    end
  end

  // Saturating count of advance cycles, including stalls and drain cycles.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_cycle_count <= '0;
    end else if (i_flush) begin
      o_cycle_count <= '0;
    end else if (advance && (o_cycle_count != 32'hFFFF_FFFF)) begin
      o_cycle_count <= o_cycle_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Self-checking bench for pipeline_stall_controller: directed scenarios followed
// by random stimulus, all compared against a behavioural model of the controller.
module tb_pipeline_stall_controller;

  localparam int DRAIN = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable, step_mode, step, flush, jmp, not_load, halt;
  logic        jump_stop, pipe_en, pc_we, if_id_we, bubble, halted;
  logic [1:0]  state;
  logic [31:0] cycle_count;

  int checks = 0;
  int fails  = 0;

  // Behavioural model: state as 0..3, drain cycles still owed, count, jump flag.
  int          m_state;
  int          m_drain_left;
  logic [31:0] m_count;
  logic        m_js;
  logic        e_go, e_pipe, e_pc, e_ifid, e_bub;

  logic [31:0] saved_count;
  int          pulses_seen;

  pipeline_stall_controller #(.DRAIN_CYCLES(DRAIN)) dut (
    .i_clk         (clk),
    .i_reset       (rst_n),
    .i_enable      (enable),
    .i_step_mode   (step_mode),
    .i_step        (step),
    .i_flush       (flush),
    .i_hd_jmp_stop (jmp),
    .i_hd_not_load (not_load),
    .i_hd_halt     (halt),
    .o_jump_stop   (jump_stop),
    .o_pipe_en     (pipe_en),
    .o_pc_we       (pc_we),
    .o_if_id_we    (if_id_we),
    .o_id_ex_bubble(bubble),
    .o_halted      (halted),
    .o_state       (state),
    .o_cycle_count (cycle_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    m_state      = 0;
    m_drain_left = 0;
    m_count      = 32'd0;
    m_js         = 1'b0;
  endtask

  // What the controller should drive this cycle, from the model and current inputs.
  task automatic computeExpected();
    e_go   = step_mode ? step : enable;
    e_pipe = (m_state == 1 || m_state == 2) && e_go && !flush;
    e_pc   = e_pipe && (m_state == 1) && !not_load && !halt;
    e_ifid = e_pc;
    e_bub  = e_pipe && ((m_state == 2) || not_load);
  endtask

  task automatic modelUpdate();
    computeExpected();
    if (flush) begin
      modelReset();
    end else begin
      if (e_pipe && m_count != 32'hFFFF_FFFF) m_count = m_count + 1;
      case (m_state)
        0: if (e_go) m_state = 1;
        1: if (e_pipe) begin
             if (!not_load && halt) begin
               m_state      = 2;
               m_drain_left = DRAIN;
               m_js         = 1'b0;
             end else begin
               m_js = jmp;
             end
           end
        2: if (e_pipe) begin
             m_drain_left = m_drain_left - 1;
             if (m_drain_left == 0) m_state = 3;
           end
        default: ;
      endcase
    end
  endtask

  task automatic applyStimulus(input logic en, input logic sm, input logic st, input logic fl,
                               input logic j, input logic nl, input logic ht);
    enable    = en;
    step_mode = sm;
    step      = st;
    flush     = fl;
    jmp       = j;
    not_load  = nl;
    halt      = ht;
  endtask

  task automatic checkOutput();
    computeExpected();
    check("state",       {30'd0, state},  m_state);
    check("pipe_en",     pipe_en,         e_pipe);
    check("pc_we",       pc_we,           e_pc);
    check("if_id_we",    if_id_we,        e_ifid);
    check("bubble",      bubble,          e_bub);
    check("halted",      halted,          (m_state == 3));
    check("jump_stop",   jump_stop,       m_js);
    check("cycle_count", cycle_count,     m_count);
  endtask

  // Cycle is split so directed steps can add checks mid-cycle.
  task automatic toNegedge();
    @(negedge clk);
    checkOutput();
  endtask

  task automatic finishCycle();
    @(posedge clk);
    modelUpdate();
    #1;
  endtask

  task automatic runCycle();
    toNegedge();
    finishCycle();
  endtask

  initial begin
    $display("[TB] starting");
    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    modelReset();
    #2;
    check("reset_state", {30'd0, state}, 32'd0);
    check("reset_count", cycle_count, 32'd0);
    check("reset_jump",  jump_stop, 1'b0);
    check("reset_pipe",  pipe_en, 1'b0);
    check("reset_halt",  halted, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Idle with no run request, then the start cycle (no advance).
    runCycle();
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    toNegedge();
    check("start_no_adv", pipe_en, 1'b0);
    finishCycle();
    check("start_run", {30'd0, state}, 32'd1);

    // Load-use stall followed by a normal advance.
    saved_count = m_count;
    applyStimulus(1, 0, 0, 0, 0, 1, 0);
    toNegedge();
    check("lu_pipe", pipe_en, 1'b1);
    check("lu_pc",   pc_we, 1'b0);
    check("lu_bub",  bubble, 1'b1);
    finishCycle();
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    toNegedge();
    check("lu_pc_next", pc_we, 1'b1);
    finishCycle();
    check("lu_count", cycle_count, saved_count + 32'd2);

    // Branch stall: jump_stop rises for one cycle.
    applyStimulus(1, 0, 0, 0, 1, 1, 0);
    runCycle();
    check("br_js_set", jump_stop, 1'b1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    runCycle();
    check("br_js_clr", jump_stop, 1'b0);

    // HALT acceptance and drain; hazard inputs ignored while draining.
    applyStimulus(1, 0, 0, 0, 0, 0, 1);
    runCycle();
    saved_count = m_count;
    applyStimulus(1, 0, 0, 0, 1, 1, 1);
    for (int i = 0; i < DRAIN; i++) begin
      toNegedge();
      check("drain_state", {30'd0, state}, 32'd2);
      check("drain_bub", bubble, 1'b1);
      finishCycle();
    end
    toNegedge();
    check("halted_state", {30'd0, state}, 32'd3);
    check("halted_flag", halted, 1'b1);
    check("halted_count", cycle_count, saved_count + DRAIN);
    check("halted_pipe", pipe_en, 1'b0);
    finishCycle();

    // Flush from HALTED, then restart.
    applyStimulus(1, 0, 0, 1, 0, 0, 0);
    toNegedge();
    check("flush_pipe", pipe_en, 1'b0);
    finishCycle();
    check("flush_state", {30'd0, state}, 32'd0);
    check("flush_halted", halted, 1'b0);
    check("flush_count", cycle_count, 32'd0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    runCycle();
    check("restart_run", {30'd0, state}, 32'd1);

    // Step mode: three isolated pulses, jump_stop held between them.
    pulses_seen = 0;
    applyStimulus(1, 1, 0, 0, 0, 0, 0);
    runCycle();
    for (int p = 0; p < 3; p++) begin
      applyStimulus(1, 1, 1, 0, (p == 0), (p == 0), 0);
      toNegedge();
      if (pipe_en === 1'b1) pulses_seen++;
      finishCycle();
      applyStimulus(1, 1, 0, 0, 0, 0, 0);
      for (int g = 0; g < 2; g++) begin
        toNegedge();
        if (pipe_en === 1'b1) pulses_seen++;
        finishCycle();
        if (p == 0) check("step_js_hold", jump_stop, 1'b1);
      end
    end
    check("step_pulses", pulses_seen, 32'd3);
    check("step_count", cycle_count, 32'd3);

    // Asynchronous reset in the middle of a drain (two drain cycles left).
    applyStimulus(1, 0, 0, 0, 0, 0, 1);
    runCycle();
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    runCycle();
    runCycle();
    #1;
    rst_n = 1'b0;
    #1;
    check("areset_state", {30'd0, state}, 32'd0);
    check("areset_count", cycle_count, 32'd0);
    modelReset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    runCycle();
    check("areset_idle", {30'd0, state}, 32'd0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    runCycle();

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      applyStimulus(($urandom % 4) != 0, ($urandom % 5) == 0, $urandom % 2,
                    ($urandom % 24) == 0, $urandom % 2, ($urandom % 4) == 0,
                    ($urandom % 10) == 0);
      runCycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
